// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Data-memory responder on the target side of the core's
//               load/store port. Accepts one request at a time through a
//               valid/ready handshake, inserts WAIT_CYCLES wait states, then
//               commits a byte/half/word store or returns a lane-aligned,
//               sign- or zero-extended load result with a one-cycle strobe.
// Ports       : clk, reset (async, active-high)
//               req_valid/req_ready handshake; req_we, req_addr, req_wdata,
//               req_size (00 byte, 01 half, 1x word), req_unsigned
//               rsp_valid (1-cycle strobe), rsp_rdata (held), rsp_err
// Parameters  : DEPTH_WORDS (power of two, >= 4), WAIT_CYCLES (0..15)
// Options     : `define DMEM_RESP_MISALIGN_ERR_EN to flag misaligned half/word
//               accesses (no write, rdata=0, rsp_err=1). Undefined: low
//               address bits below the access size are ignored, rsp_err=0.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         c_AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [c_AW+1:0]   addr_q;
   logic [31:0]       wdata_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              w_enter_resp;
   logic              w_from_req;
   logic              w_we;
   logic [c_AW+1:0]   w_addr;
   logic [31:0]       w_wdata;
   logic [1:0]        w_size;
   logic              w_uns;
   logic              w_mis;
   logic [c_AW-1:0]   w_idx;
   logic [3:0]        w_be;
   logic [31:0]       w_wdat;
   logic [31:0]       w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic              w_unused_addr;

   // Address bits above the RAM index only alias; they are never decoded.
   assign w_unused_addr = ^req_addr[31:c_AW+2];

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      w_enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_d      = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = c_WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // With zero wait states the access completes on the accept edge itself,
   // so the live request fields are used instead of the latched copy.
   assign w_from_req = (state_q == S_IDLE);
   assign w_we       = w_from_req ? req_we              : we_q;
   assign w_addr     = w_from_req ? req_addr[c_AW+1:0]  : addr_q;
   assign w_wdata    = w_from_req ? req_wdata           : wdata_q;
   assign w_size     = w_from_req ? req_size            : size_q;
   assign w_uns      = w_from_req ? req_unsigned        : uns_q;
   assign w_idx      = w_addr[c_AW+1:2];

`ifdef DMEM_RESP_MISALIGN_ERR_EN
   assign w_mis = ((w_size == 2'b01) && w_addr[0]) ||
                  (w_size[1] && (w_addr[1:0] != 2'b00));
`else
   assign w_mis = 1'b0;
`endif

   // Store lane enables and lane-replicated write data.
   always_comb begin
      w_be   = 4'b1111;
      w_wdat = w_wdata;
      case (w_size)
         2'b00: begin
            w_be   = 4'b0001 << w_addr[1:0];
            w_wdat = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdat = {2{w_wdata[15:0]}};
         end
         default: begin
            w_be   = 4'b1111;
            w_wdat = w_wdata;
         end
      endcase
   end

   // Load lane selection and extension.
   assign w_word = mem_q[w_idx];
   assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_byte = w_word[7:0];
      case (w_addr[1:0])
         2'b00:   w_byte = w_word[7:0];
         2'b01:   w_byte = w_word[15:8];
         2'b10:   w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
   end

   always_comb begin
      w_load = w_word;
      case (w_size)
         2'b00:   w_load = w_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = w_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
      rdata_d = (w_we || w_mis) ? 32'd0 : w_load;
   end

   // ------------------------------------------------------- state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_from_req && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr[c_AW+1:0];
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
         end
         if (w_enter_resp) begin
            rdata_q <= rdata_d;
            err_q   <= w_mis;
         end
      end
   end

   // RAM is not reset; a store only commits on the edge entering RESP, so a
   // reset during WAIT drops it before it reaches the array.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_we && !w_mis) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) mem_q[w_idx][b*8 +: 8] <= w_wdat[b*8 +: 8];
         end
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Self-checking bench for dmem_resp. Instance u_dut_a uses the
//               default parameters (64 words, 2 wait states); u_dut_b uses
//               zero wait states. Both share the request fields and have
//               separate valid strobes. Expected responses are queued when a
//               request is driven and popped when the response strobe fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        a_valid, b_valid;
   logic        r_we;
   logic [31:0] r_addr, r_wdata;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_err, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        sel_b;
   logic        m_ready, m_rsp_valid, m_err;
   logic [31:0] m_rdata;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .reset(rst), .req_valid(a_valid), .req_ready(a_ready),
      .req_we(r_we), .req_addr(r_addr), .req_wdata(r_wdata), .req_size(r_size),
      .req_unsigned(r_uns), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
      .rsp_err(a_err)
   );

   dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(rst), .req_valid(b_valid), .req_ready(b_ready),
      .req_we(r_we), .req_addr(r_addr), .req_wdata(r_wdata), .req_size(r_size),
      .req_unsigned(r_uns), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
      .rsp_err(b_err)
   );

   assign m_ready     = sel_b ? b_ready     : a_ready;
   assign m_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
   assign m_rdata     = sel_b ? b_rdata     : a_rdata;
   assign m_err       = sel_b ? b_err       : a_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete request: drive, queue the expectation, scramble inputs
   // after acceptance, wait (bounded) for the strobe, then compare.
   task automatic xfer(input logic to_b, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input string tag);
      int   lat;
      logic got;
      exp_t e;
      sel_b = to_b;
      @(negedge clk);
      r_we = we; r_addr = addr; r_wdata = wdata; r_size = size; r_uns = uns;
      if (to_b) b_valid = 1'b1; else a_valid = 1'b1;
      #1;
      chk({tag, ":ready_idle"}, 32'(m_ready), 32'd1);
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb.push_back(e);
      @(posedge clk);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            a_valid = 1'b0; b_valid = 1'b0;
            r_we = ~we; r_addr = addr ^ 32'h0000_00FF; r_wdata = ~wdata;
            r_size = ~size; r_uns = ~uns;
         end
         #1;
         if (m_rsp_valid) got = 1'b1;
         else chk({tag, ":ready_wait"}, 32'(m_ready), 32'd0);
      end
      chk({tag, ":rsp_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
         chk({tag, ":ready_resp"}, 32'(m_ready), 32'd0);
         e = sb.pop_front();
         chk({tag, ":rdata"}, m_rdata, e.rdata);
         chk({tag, ":err"}, 32'(m_err), 32'(e.err));
         @(negedge clk);
         #1;
         chk({tag, ":strobe_1cyc"}, 32'(m_rsp_valid), 32'd0);
         chk({tag, ":ready_back"}, 32'(m_ready), 32'd1);
         chk({tag, ":rdata_held"}, m_rdata, e.rdata);
      end
   endtask

   initial begin
      exp_t e;
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; sel_b = 1'b0;
      r_we = 1'b0; r_addr = 32'd0; r_wdata = 32'd0; r_size = 2'b10; r_uns = 1'b0;

      // Asynchronous reset: outputs must settle before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst:a_ready", 32'(a_ready), 32'd1);
      chk("rst:a_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst:a_rdata", a_rdata, 32'd0);
      chk("rst:a_err", 32'(a_err), 32'd0);
      chk("rst:b_ready", 32'(b_ready), 32'd1);
      chk("rst:b_rsp_valid", 32'(b_rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Word store/load round trip.
      xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 3, "st_w10");
      xfer(1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 3, "ld_w10");
      // Byte store and signed/unsigned byte loads.
      xfer(1'b0, 1'b1, 32'h11, 32'h123456AA, 2'b00, 1'b0, 32'h0,        1'b0, 3, "st_b11");
      xfer(1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADAAEF, 1'b0, 3, "ld_w10b");
      xfer(1'b0, 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'hFFFFFFAA, 1'b0, 3, "ld_bs11");
      xfer(1'b0, 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h000000AA, 1'b0, 3, "ld_bu11");
      // Half stores and loads.
      xfer(1'b0, 1'b1, 32'h12, 32'hABCD1234, 2'b01, 1'b0, 32'h0,        1'b0, 3, "st_h12");
      xfer(1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'h1234AAEF, 1'b0, 3, "ld_w10h");
      xfer(1'b0, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'h00001234, 1'b0, 3, "ld_hs12");
      xfer(1'b0, 1'b1, 32'h10, 32'h00008001, 2'b01, 1'b0, 32'h0,        1'b0, 3, "st_h10");
      xfer(1'b0, 1'b0, 32'h10, 32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0, 3, "ld_hs10");
      xfer(1'b0, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h00008001, 1'b0, 3, "ld_hu10");
      xfer(1'b0, 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h00000012, 1'b0, 3, "ld_bu13");
      // Misaligned word/half accesses and address aliasing.
`ifdef DMEM_RESP_MISALIGN_ERR_EN
      xfer(1'b0, 1'b0, 32'h13,  32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 3, "ld_w13");
      xfer(1'b0, 1'b1, 32'h13,  32'h0BADF00D, 2'b10, 1'b0, 32'h0,        1'b1, 3, "st_w13");
      xfer(1'b0, 1'b0, 32'h110, 32'h0,        2'b10, 1'b0, 32'h12348001, 1'b0, 3, "ld_w110");
      xfer(1'b0, 1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1, 3, "ld_hs11");
`else
      xfer(1'b0, 1'b0, 32'h13,  32'h0,        2'b10, 1'b0, 32'h12348001, 1'b0, 3, "ld_w13");
      xfer(1'b0, 1'b1, 32'h13,  32'h0BADF00D, 2'b11, 1'b0, 32'h0,        1'b0, 3, "st_w13");
      xfer(1'b0, 1'b0, 32'h110, 32'h0,        2'b10, 1'b0, 32'h0BADF00D, 1'b0, 3, "ld_w110");
      xfer(1'b0, 1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'hFFFFF00D, 1'b0, 3, "ld_hs11");
`endif

      // Reset during WAIT discards a pending store.
      xfer(1'b0, 1'b1, 32'h20, 32'h13579BDF, 2'b10, 1'b0, 32'h0,        1'b0, 3, "st_x0");
      xfer(1'b0, 1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h13579BDF, 1'b0, 3, "ld_x0");
      sel_b = 1'b0;
      @(negedge clk);
      r_we = 1'b1; r_addr = 32'h20; r_wdata = 32'h55555555; r_size = 2'b10; r_uns = 1'b0;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      chk("rstw:in_wait", 32'(a_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("rstw:ready", 32'(a_ready), 32'd1);
      chk("rstw:rsp_valid", 32'(a_rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("rstw:no_rsp", 32'(a_rsp_valid), 32'd0);
         chk("rstw:idle", 32'(a_ready), 32'd1);
      end
      xfer(1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h13579BDF, 1'b0, 3, "ld_x0_after");

      // Zero wait states: aliasing store/load, then back-to-back loads.
      xfer(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0, 1, "b_st100");
      xfer(1'b1, 1'b0, 32'h000, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1, "b_ld000");
      sel_b = 1'b1;
      @(negedge clk);
      r_we = 1'b0; r_addr = 32'h0; r_size = 2'b10; r_uns = 1'b0;
      b_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("b2b:ready", 32'(b_ready), 32'((i % 2) == 0));
         chk("b2b:rsp_valid", 32'(b_rsp_valid), 32'((i % 2) == 1));
         if (b_ready) begin
            e.rdata = 32'hCAFEF00D;
            e.err   = 1'b0;
            sb.push_back(e);
         end
         if (b_rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("b2b:rdata", b_rdata, e.rdata);
         end
         if (i == 5) b_valid = 1'b0;
         @(negedge clk);
      end
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
